// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between the stream reader, its FIFO read port and the downstream sink.
// master: the reader (drives pop strobe and stream word); slave: FIFO/sink side.
// Signals: fifo_empty, fifo_rd_dat, fifo_rd_en (FIFO port); out_vld, out_dat, out_rdy (stream).
`timescale 1ns/1ps
interface fifo_stream_reader_if #(
    parameter int DataWidth = 32
);
    logic                 fifo_empty;
    logic [DataWidth-1:0] fifo_rd_dat;
    logic                 fifo_rd_en;
    logic                 out_vld;
    logic [DataWidth-1:0] out_dat;
    logic                 out_rdy;

    modport master (
        input  fifo_empty,
        input  fifo_rd_dat,
        output fifo_rd_en,
        output out_vld,
        output out_dat,
        input  out_rdy
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_dat,
        input  fifo_rd_en,
        input  out_vld,
        input  out_dat,
        output out_rdy
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops a programmed number of FIFO words and re-presents them as a valid/ready stream.
// Latency: word popped at edge N is valid in cycle N+1 (empty buffer); 1 word/cycle sustained.
// Backpressure: 2-entry skid buffer; pops stall when it is full, so out_rdy never reaches fifo_rd_en.
// Ports: clk, rst (async, active-high); start_i pulse, word_limit_i (0 = unlimited), stop_i level;
//        busy_o (RUN/FLUSH), done_o (1-cycle pulse), word_count_o (words popped);
//        bus: FIFO read port and output stream (fifo_stream_reader_if.master).
`timescale 1ns/1ps
module fifo_stream_reader #(
    parameter int DataWidth  = 32,
    parameter int CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [CountWidth-1:0] word_limit_i,
    input  logic                  stop_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CountWidth-1:0] word_count_o,
    fifo_stream_reader_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                  state_q;
    logic                    busy_q;
    logic                    done_q;
    logic [CountWidth-1:0]   limit_q;
    logic [CountWidth-1:0]   count_q;
    logic [CountWidth-1:0]   count_inc;

    // Output buffer: head_q is the oldest word, tail_q the second one.
    logic [1:0]              occ_q,  occ_d;
    logic [DataWidth-1:0]    head_q, head_d;
    logic [DataWidth-1:0]    tail_q, tail_d;

    logic                    limit_reached;
    logic                    rd_en;
    logic                    out_pop;

    assign limit_reached = (limit_q != '0) && (count_q == limit_q);

    // Only registered state plus the FIFO flag and stop qualify the pop; out_rdy is
    // deliberately absent so the downstream ready never feeds the FIFO pointer logic.
    assign rd_en = (state_q == RUN) && !bus.fifo_empty && (occ_q < 2'd2)
                   && !stop_i && !limit_reached;

    assign out_pop = (occ_q != 2'd0) && bus.out_rdy;

    // Saturating increment; with a non-zero limit the count never gets near all-ones.
    assign count_inc = (count_q == '1) ? count_q : count_q + CountWidth'(1);

    // ------------------------------------------------------------------
    // Buffer next state
    // ------------------------------------------------------------------
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case ({rd_en, out_pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = bus.fifo_rd_dat;
                    occ_d  = 2'd1;
                end else begin
                    tail_d = bus.fifo_rd_dat;
                    occ_d  = 2'd2;
                end
            end
            2'b01: begin
                // Shift the second entry forward; with occ==1 tail is a stale copy.
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Push needs occ<2 and pop needs occ>0, so occ is 1 here: replace the head.
                head_d = bus.fifo_rd_dat;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM with registered busy/done
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            limit_q <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        limit_q <= word_limit_i;
                        count_q <= '0;
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        count_q <= count_inc;
                    end
                    if (stop_i || (rd_en && (limit_q != '0) && (count_inc == limit_q))) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Wait for the downstream to take every buffered word.
                    if (occ_q == 2'd0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_vld    = (occ_q != 2'd0);
    assign bus.out_dat    = head_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign word_count_o   = count_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
`timescale 1ns/1ps
module tb_fifo_stream_reader;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic [CW-1:0] limit;
    logic          busy;
    logic          done;
    logic [CW-1:0] wcount;

    fifo_stream_reader_if #(.DataWidth(DW)) bus ();

    fifo_stream_reader #(.DataWidth(DW), .CountWidth(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .word_limit_i (limit),
        .stop_i       (stop),
        .busy_o       (busy),
        .done_o       (done),
        .word_count_o (wcount),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model: head word visible whenever non-empty, consumed at the pop edge.
    logic [DW-1:0] fmem [0:255];
    int fwr = 0;     // written by the stimulus process only
    int frd = 0;     // written by the monitor only
    int fskip = 0;   // flush offset, stimulus process only
    assign bus.fifo_empty  = (fwr == frd + fskip);
    assign bus.fifo_rd_dat = fmem[8'(frd + fskip)];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor (samples 1 ns before each rising edge) ----------------
    logic [DW-1:0] rx_dat [0:255];
    int            rx_cyc [0:255];
    int rx_n = 0, pop_cnt = 0, done_cnt = 0, cyc = 0;
    int occ_est = 0, occ_err = 0, stab_err = 0, empty_viol = 0;

    initial begin
        bit            pend;
        bit            acc;
        bit            prev_stall;
        logic [DW-1:0] prev_dat;
        pend = 0;
        prev_stall = 0;
        prev_dat = '0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                occ_est    = 0;
                prev_stall = 0;
                pend       = 0;
            end else begin
                pend = bus.fifo_rd_en;
                if (bus.fifo_rd_en && bus.fifo_empty) empty_viol++;
                if (prev_stall && (!bus.out_vld || bus.out_dat !== prev_dat)) stab_err++;
                acc = bus.out_vld && bus.out_rdy;
                if (acc) begin
                    rx_dat[rx_n] = bus.out_dat;
                    rx_cyc[rx_n] = cyc;
                    rx_n++;
                end
                if (bus.fifo_rd_en) pop_cnt++;
                occ_est = occ_est + int'(bus.fifo_rd_en) - int'(acc);
                if (occ_est > 2 || occ_est < 0) occ_err++;
                if (done) done_cnt++;
                prev_stall = bus.out_vld && !bus.out_rdy;
                prev_dat   = bus.out_dat;
            end
            @(posedge clk);
            #1;
            if (pend) frd++;
            pend = 0;
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    int st_cyc = 0;
    logic [3:0] rdy_pat = 4'b1001;   // out_rdy sequence 1,0,0,1 (bit 0 first)

    task automatic push_word(input logic [DW-1:0] d);
        fmem[8'(fwr)] = d;
        fwr++;
    endtask

    task automatic flush_fifo();
        fskip = fwr - frd;
    endtask

    // Limit is dropped back to 0 after the pulse: the DUT must have sampled it.
    task automatic pulse_start(input logic [CW-1:0] lim);
        @(negedge clk);
        limit  = lim;
        start  = 1'b1;
        st_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        limit = '0;
    endtask

    task automatic run_until_done(input int stop_after, input bit toggle_rdy, input int budget);
        int pbase;
        int dbase;
        int k;
        pbase = pop_cnt;
        dbase = done_cnt;
        k = 0;
        while (done_cnt == dbase && k < budget) begin
            if (stop_after >= 0 && (pop_cnt - pbase) >= stop_after) stop = 1'b1;
            if (toggle_rdy) bus.out_rdy = rdy_pat[k % 4];
            @(negedge clk);
            k++;
        end
        chk("done_within_budget", 32'(done_cnt > dbase), 32'd1);
        stop = 1'b0;
        bus.out_rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk("done_single_pulse", 32'(done_cnt - dbase), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [DW-1:0] base;
        int            n_words;
        logic [CW-1:0] lim;
        int            stop_after;   // -1: never stop
        int            exp_pops;
        int            exp_left;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rx0;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        limit = '0;
        bus.out_rdy = 1'b1;

        vecs[0] = '{32'h10, 4,  16'd4, -1, 4, 0};   // basic 4-word transfer
        vecs[1] = '{32'h30, 5,  16'd3, -1, 3, 2};   // limit below FIFO depth
        vecs[2] = '{32'h50, 10, 16'd0,  6, 6, 4};   // unlimited, stop after 6 pops
        vecs[3] = '{32'h70, 1,  16'd1, -1, 1, 0};   // single word
        vecs[4] = '{32'h90, 3,  16'd0,  0, 0, 3};   // stop right after start

        #12;
        chk("reset_out_vld", 32'(bus.out_vld), 32'd0);
        chk("reset_fifo_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_wcount", 32'(wcount), 32'd0);
        chk("reset_out_dat", bus.out_dat, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- table-driven transfers ----------------
        for (int v = 0; v < 5; v++) begin
            flush_fifo();
            for (int i = 0; i < vecs[v].n_words; i++) push_word(vecs[v].base + DW'(i));
            rx0 = rx_n;
            pulse_start(vecs[v].lim);
            run_until_done(vecs[v].stop_after, 1'b0, 100);
            chk("vec_wcount", 32'(wcount), 32'(vecs[v].exp_pops));
            chk("vec_rx_count", 32'(rx_n - rx0), 32'(vecs[v].exp_pops));
            for (int i = 0; i < vecs[v].exp_pops; i++)
                chk("vec_rx_data", rx_dat[rx0 + i], vecs[v].base + DW'(i));
            chk("vec_fifo_left", 32'(fwr - frd - fskip), 32'(vecs[v].exp_left));
            if (vecs[v].exp_pops > 0) begin
                chk("vec_first_latency", 32'(rx_cyc[rx0] - st_cyc), 32'd2);
                chk("vec_back_to_back", 32'(rx_cyc[rx0 + vecs[v].exp_pops - 1] - rx_cyc[rx0]),
                    32'(vecs[v].exp_pops - 1));
            end
        end

        // ---------------- out_rdy toggling 1,0,0,1 over 8 words ----------------
        flush_fifo();
        for (int i = 0; i < 8; i++) push_word(32'hA0 + DW'(i));
        rx0 = rx_n;
        pulse_start(16'd8);
        run_until_done(-1, 1'b1, 200);
        chk("stall_rx_count", 32'(rx_n - rx0), 32'd8);
        for (int i = 0; i < 8; i++) chk("stall_rx_data", rx_dat[rx0 + i], 32'hA0 + DW'(i));
        chk("stall_wcount", 32'(wcount), 32'd8);

        // ---------------- FIFO runs dry, refilled 3 cycles later; start while busy ----------
        flush_fifo();
        push_word(32'hC0);
        push_word(32'hC1);
        rx0 = rx_n;
        pulse_start(16'd5);
        for (int k = 0; k < 20; k++) begin
            if (bus.fifo_empty) break;
            @(negedge clk);
        end
        chk("dry_fifo_empty_seen", 32'(bus.fifo_empty), 32'd1);
        limit = 16'd2;
        start = 1'b1;      // must be ignored while busy
        @(negedge clk);
        start = 1'b0;
        limit = '0;
        repeat (2) @(negedge clk);
        chk("dry_busy_while_waiting", 32'(busy), 32'd1);
        for (int i = 2; i < 5; i++) push_word(32'hC0 + DW'(i));
        run_until_done(-1, 1'b0, 100);
        chk("dry_rx_count", 32'(rx_n - rx0), 32'd5);
        for (int i = 0; i < 5; i++) chk("dry_rx_data", rx_dat[rx0 + i], 32'hC0 + DW'(i));
        chk("dry_wcount", 32'(wcount), 32'd5);

        // ---------------- async reset with a full buffer ----------------
        flush_fifo();
        for (int i = 0; i < 5; i++) push_word(32'hE0 + DW'(i));
        bus.out_rdy = 1'b0;
        pulse_start(16'd0);
        repeat (4) @(negedge clk);
        chk("pre_reset_out_vld", 32'(bus.out_vld), 32'd1);
        chk("pre_reset_buffer_full", 32'(bus.fifo_rd_en), 32'd0);
        chk("pre_reset_wcount", 32'(wcount), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_vld", 32'(bus.out_vld), 32'd0);
        chk("async_rst_out_dat", bus.out_dat, 32'd0);
        chk("async_rst_fifo_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_wcount", 32'(wcount), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_rdy = 1'b1;
        flush_fifo();
        push_word(32'hF5);
        rx0 = rx_n;
        @(negedge clk);
        pulse_start(16'd1);
        run_until_done(-1, 1'b0, 50);
        chk("post_rst_rx_count", 32'(rx_n - rx0), 32'd1);
        chk("post_rst_rx_data", rx_dat[rx0], 32'hF5);
        chk("post_rst_wcount", 32'(wcount), 32'd1);

        // ---------------- protocol invariants over the whole run ----------------
        chk("pop_while_empty", 32'(empty_viol), 32'd0);
        chk("out_dat_unstable_in_stall", 32'(stab_err), 32'd0);
        chk("buffer_occupancy_bound", 32'(occ_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
